// File: rtl/lsu_sbuf.sv
// lsu_sbuf: load/store unit between the execution stage and the data TCM.
// Loads go straight to the TCM and return one cycle later. Stores are posted
// into a small circular buffer and written back whenever the TCM port is not
// needed by a load. Misaligned or out-of-window requests are accepted and
// reported through a registered one-cycle exception pulse.
//
// Handshake: a request is taken at the rising clock edge where req_v=1 and
// stall=0; while stall=1 the source holds minst/addr/wdata/rd/fence unchanged.
// rd_v and exc_v are single-cycle pulses without back-pressure.
module lsu_sbuf #(
    parameter int          ADDR_W    = 12,
    parameter int          SB_DEPTH  = 4,
    parameter logic [31:0] DTCM_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_v,
    input  logic [3:0]        minst,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd,
    input  logic              fence,
    output logic              stall,
    output logic              rd_v,
    output logic [4:0]        rd_wb,
    output logic [31:0]       rd_data,
    output logic              exc_v,
    output logic [1:0]        exc_cause,
    output logic [31:0]       exc_addr,
    output logic              sb_empty,
    output logic              dtcm_en,
    output logic [3:0]        dtcm_we,
    output logic [ADDR_W-1:0] dtcm_addr,
    output logic [31:0]       dtcm_wdata,
    input  logic [31:0]       dtcm_rdata
);

    localparam int PTR_W   = $clog2(SB_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WIN_LSB = ADDR_W + 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);
    localparam logic [31:0]      BASE     = DTCM_BASE;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
    logic [ADDR_W-1:0] sb_addr_d [SB_DEPTH];
    logic [3:0]        sb_mask_q [SB_DEPTH];
    logic [3:0]        sb_mask_d [SB_DEPTH];
    logic [31:0]       sb_data_q [SB_DEPTH];
    logic [31:0]       sb_data_d [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_valid_q, sb_valid_d;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sb_empty_q, sb_empty_d;
    logic             fence_pend_q, fence_pend_d;

    logic             ld_pend_q, ld_pend_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_off_q, ld_off_d;

    logic             exc_v_q, exc_v_d;
    logic [1:0]       exc_cause_q, exc_cause_d;
    logic [31:0]      exc_addr_q, exc_addr_d;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    logic              is_store;
    logic [1:0]        req_size;
    logic              misalign;
    logic              out_of_range;
    logic [ADDR_W-1:0] req_waddr;
    logic [3:0]        st_mask;
    logic [31:0]       st_data;
    logic              hazard;

    // Classify the request: size, alignment, window check, store lanes.
    always_comb begin
        is_store     = minst[3];
        req_size     = minst[1:0];
        req_waddr    = addr[WIN_LSB-1:2];
        misalign     = ((req_size == 2'b01) && addr[0]) ||
                       (req_size[1] && (addr[1:0] != 2'b00));
        out_of_range = (addr[31:WIN_LSB] != BASE[31:WIN_LSB]);
        st_mask      = 4'b1111;
        st_data      = wdata;
        case (req_size)
            2'b00: begin
                st_mask = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_mask = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // A load may not overtake a buffered store to the same word.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid_q[i] && (sb_addr_q[i] == req_waddr)) begin
                hazard = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Acceptance and TCM port arbitration
    // ---------------------------------------------------------------
    logic sb_full;
    logic sb_nonempty;
    logic fence_blk;
    logic push;
    logic load_go;
    logic exc_go;
    logic drain;

    // Decide what happens to the request and who owns the TCM port.
    // A full buffer always drains; otherwise a load beats the drain.
    always_comb begin
        sb_full     = (count_q == FULL_CNT);
        sb_nonempty = (count_q != '0);
        fence_blk   = (fence || fence_pend_q) && !sb_empty_q;
        stall       = 1'b0;
        push        = 1'b0;
        load_go     = 1'b0;
        exc_go      = 1'b0;
        if (fence_blk) begin
            stall = 1'b1;
        end else if (req_v) begin
            if (misalign || out_of_range) begin
                exc_go = 1'b1;
            end else if (is_store) begin
                if (sb_full) stall = 1'b1;
                else         push  = 1'b1;
            end else begin
                if (sb_full || hazard) stall   = 1'b1;
                else                   load_go = 1'b1;
            end
        end
        drain = sb_nonempty && !load_go;
    end

    // Drive the TCM: the head entry when draining, otherwise the load.
    always_comb begin
        dtcm_en    = load_go || drain;
        dtcm_we    = 4'b0000;
        dtcm_addr  = req_waddr;
        dtcm_wdata = 32'h0;
        if (drain) begin
            dtcm_we    = sb_mask_q[head_q];
            dtcm_addr  = sb_addr_q[head_q];
            dtcm_wdata = sb_data_q[head_q];
        end
    end

    // ---------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------
    // Buffer pointers, occupancy, entry contents and fence tracking.
    always_comb begin
        sb_addr_d  = sb_addr_q;
        sb_mask_d  = sb_mask_q;
        sb_data_d  = sb_data_q;
        sb_valid_d = sb_valid_q;
        head_d     = head_q + PTR_W'(drain);
        tail_d     = tail_q + PTR_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(drain);
        if (drain) begin
            sb_valid_d[head_q] = 1'b0;
        end
        if (push) begin
            sb_addr_d[tail_q]  = req_waddr;
            sb_mask_d[tail_q]  = st_mask;
            sb_data_d[tail_q]  = st_data;
            sb_valid_d[tail_q] = 1'b1;
        end
        sb_empty_d   = (count_d == '0);
        // A fence stays in force until the buffer has emptied.
        fence_pend_d = fence_blk && (count_d != '0);
    end

    // Load return bookkeeping and exception capture.
    always_comb begin
        ld_pend_d   = load_go;
        ld_rd_d     = load_go ? rd : ld_rd_q;
        ld_f3_d     = load_go ? minst[2:0] : ld_f3_q;
        ld_off_d    = load_go ? addr[1:0] : ld_off_q;
        exc_v_d     = exc_go;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        if (exc_go) begin
            exc_cause_d = {~misalign, is_store};
            exc_addr_d  = addr;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= '0;
                sb_mask_q[i] <= '0;
                sb_data_q[i] <= '0;
            end
            sb_valid_q   <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            sb_empty_q   <= 1'b1;
            fence_pend_q <= 1'b0;
            ld_pend_q    <= 1'b0;
            ld_rd_q      <= '0;
            ld_f3_q      <= '0;
            ld_off_q     <= '0;
            exc_v_q      <= 1'b0;
            exc_cause_q  <= '0;
            exc_addr_q   <= '0;
        end else begin
            sb_addr_q    <= sb_addr_d;
            sb_mask_q    <= sb_mask_d;
            sb_data_q    <= sb_data_d;
            sb_valid_q   <= sb_valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            sb_empty_q   <= sb_empty_d;
            fence_pend_q <= fence_pend_d;
            ld_pend_q    <= ld_pend_d;
            ld_rd_q      <= ld_rd_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            exc_v_q      <= exc_v_d;
            exc_cause_q  <= exc_cause_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    // ---------------------------------------------------------------
    // Load writeback
    // ---------------------------------------------------------------
    logic [31:0] ld_word;
    logic [31:0] ld_ext;

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        ld_word = dtcm_rdata >> {ld_off_q, 3'b000};
        case (ld_f3_q[1:0])
            2'b00:   ld_ext = {{24{~ld_f3_q[2] & ld_word[7]}}, ld_word[7:0]};
            2'b01:   ld_ext = {{16{~ld_f3_q[2] & ld_word[15]}}, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
        rd_data = ld_pend_q ? ld_ext : 32'h0;
    end

    assign rd_v      = ld_pend_q;
    assign rd_wb     = ld_rd_q;
    assign exc_v     = exc_v_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;
    assign sb_empty  = sb_empty_q;

endmodule
